// File: rtl/encoder_8to3_irq.sv
// encoder_8to3_irq: 8-to-3 priority encoder for active-low interrupt requests,
// with pending capture, a present/ack handshake and a sticky overflow flag.
//
// state   | meaning
// IDLE    | no code presented; leaves when en=1 and a request is pending
// PRESENT | valid=1; {A,B,C} held stable until ack
module encoder_8to3_irq #(
  parameter int LEVEL_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req_n,
  input  logic       ack,
  input  logic       ovf_clr,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       valid,
  output logic       ovf
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pending;
  logic [7:0] r_prev;
  logic [2:0] r_code;
  logic       r_ovf;

  logic [2:0] w_code_nxt;
  logic [7:0] w_set;
  logic [7:0] w_clr;
  logic [7:0] w_pending_nxt;
  logic [2:0] w_top;
  logic       w_ovf_hit;
  logic       w_ovf_nxt;

  // Capture: falling edge against the previous sample, or plain low level.
  always_comb begin
    if (LEVEL_MODE != 0) begin
      w_set = ~req_n;
    end else begin
      w_set = r_prev & ~req_n;
    end
  end

  always_comb begin
    w_clr = 8'h00;
    if ((r_state == PRESENT) && ack) begin
      w_clr = 8'h01 << r_code;
    end
  end

  // Set wins over clear for the same bit.
  always_comb begin
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
  end

  // Highest index wins; later loop iterations override lower ones.
  always_comb begin
    w_top = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_pending[i]) begin
        w_top = 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    case (r_state)
      IDLE: begin
        if (en && (r_pending != 8'h00)) begin
          w_state_nxt = PRESENT;
          w_code_nxt  = w_top;
        end
      end
      PRESENT: begin
        if (ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A request lost to an already-pending bit; a bit being acked this edge is not lost.
  always_comb begin
    w_ovf_hit = 1'b0;
    if (LEVEL_MODE == 0) begin
      w_ovf_hit = |(w_set & r_pending & ~w_clr);
    end
    w_ovf_nxt = w_ovf_hit | (r_ovf & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= 8'h00;
      r_prev    <= 8'hFF;
      r_code    <= 3'd0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_prev    <= req_n;
      r_code    <= w_code_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  assign A     = r_code[2];
  assign B     = r_code[1];
  assign C     = r_code[0];
  assign valid = (r_state == PRESENT);
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_encoder_8to3_irq.sv
// Bench for encoder_8to3_irq: edge-mode and level-mode instances checked
// against a per-edge reference model, with directed steps then random traffic.
module tb_encoder_8to3_irq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req_n;
  logic       ack0;
  logic       ack1;
  logic       ovf_clr;
  logic       A0, B0, C0, valid0, ovf0;
  logic       A1, B1, C1, valid1, ovf1;

  int checks;
  int failures;

  logic [7:0] m_pend [2];
  logic [7:0] m_prev [2];
  logic       m_pres [2];
  logic [2:0] m_code [2];
  logic       m_ovf  [2];

  encoder_8to3_irq #(.LEVEL_MODE(0)) u_edge (
    .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n), .ack(ack0),
    .ovf_clr(ovf_clr), .A(A0), .B(B0), .C(C0), .valid(valid0), .ovf(ovf0)
  );

  encoder_8to3_irq #(.LEVEL_MODE(1)) u_level (
    .clk(clk), .rst_n(rst_n), .en(en), .req_n(req_n), .ack(ack1),
    .ovf_clr(ovf_clr), .A(A1), .B(B1), .C(C1), .valid(valid1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 8'h00;
      m_prev[m] = 8'hFF;
      m_pres[m] = 1'b0;
      m_code[m] = 3'd0;
      m_ovf[m]  = 1'b0;
    end
  endfunction

  // One clock edge of instance m (0 = edge capture, 1 = level capture).
  function automatic void model_edge(int m, logic a);
    logic [7:0] setv;
    logic [7:0] clrv;
    int         hi;
    setv = 8'h00;
    clrv = 8'h00;
    hi   = -1;
    if (m_pres[m] && a) clrv[m_code[m]] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (req_n[i] == 1'b0 && (m == 1 || m_prev[m][i] == 1'b1)) setv[i] = 1'b1;
    end
    for (int i = 7; i >= 0; i--) begin
      if (hi < 0 && m_pend[m][i]) hi = i;
    end
    if (m == 0 && (setv & m_pend[m] & ~clrv) != 8'h00) m_ovf[m] = 1'b1;
    else if (ovf_clr) m_ovf[m] = 1'b0;
    if (!m_pres[m]) begin
      if (en && hi >= 0) begin
        m_pres[m] = 1'b1;
        m_code[m] = 3'(hi);
      end
    end else if (a) begin
      m_pres[m] = 1'b0;
    end
    m_pend[m] = (m_pend[m] & ~clrv) | setv;
    m_prev[m] = req_n;
  endfunction

  task automatic compare_all(string tag);
    check({tag, ".code0"},  {5'd0, A0, B0, C0}, {5'd0, m_code[0]});
    check({tag, ".valid0"}, {7'd0, valid0},     {7'd0, m_pres[0]});
    check({tag, ".ovf0"},   {7'd0, ovf0},       {7'd0, m_ovf[0]});
    check({tag, ".code1"},  {5'd0, A1, B1, C1}, {5'd0, m_code[1]});
    check({tag, ".valid1"}, {7'd0, valid1},     {7'd0, m_pres[1]});
    check({tag, ".ovf1"},   {7'd0, ovf1},       {7'd0, m_ovf[1]});
  endtask

  task automatic step(string tag);
    model_edge(0, ack0);
    model_edge(1, ack1);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    req_n    = 8'hFF;
    ack0     = 1'b0;
    ack1     = 1'b0;
    ovf_clr  = 1'b0;
    model_reset();
    #1;
    compare_all("reset_async");
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset_held");
    rst_n = 1'b1;

    // single request, code 3
    en    = 1'b1;
    req_n = 8'hF7;
    step("r030_capture");
    check("r030_valid_early", {7'd0, valid0}, 8'd0);
    step("r030_present");
    check("r030_valid", {7'd0, valid0}, 8'd1);
    check("r030_code", {5'd0, A0, B0, C0}, 8'd3);
    ack0 = 1'b1; ack1 = 1'b1;
    step("r030_ack");
    ack0 = 1'b0; ack1 = 1'b0;
    check("r030_valid_drop", {7'd0, valid0}, 8'd0);
    req_n = 8'hFF;
    step("r030_idle");

    // priority order 6, 4, 1
    req_n = 8'hAD;
    step("r031_capture");
    foreach (m_code[k]) begin end
    for (int k = 0; k < 3; k++) begin
      logic [7:0] exp_code;
      exp_code = (k == 0) ? 8'd6 : (k == 1) ? 8'd4 : 8'd1;
      step("r031_present");
      check("r031_valid", {7'd0, valid0}, 8'd1);
      check("r031_code", {5'd0, A0, B0, C0}, exp_code);
      ack0 = 1'b1;
      step("r031_ack");
      ack0 = 1'b0;
      check("r031_gap", {7'd0, valid0}, 8'd0);
    end
    req_n = 8'hFF;
    ack1  = 1'b1;
    repeat (6) step("drain_a");
    ack1  = 1'b0;

    // no preemption: 2 presented, 7 arrives
    req_n = 8'hFB;
    step("r032_capture");
    step("r032_present2");
    check("r032_code2", {5'd0, A0, B0, C0}, 8'd2);
    req_n = 8'h7B;
    step("r032_hold_a");
    check("r032_hold_a_code", {5'd0, A0, B0, C0}, 8'd2);
    step("r032_hold_b");
    check("r032_hold_b_code", {5'd0, A0, B0, C0}, 8'd2);
    ack0 = 1'b1;
    step("r032_ack2");
    ack0 = 1'b0;
    step("r032_present7");
    check("r032_code7", {5'd0, A0, B0, C0}, 8'd7);
    ack0 = 1'b1;
    step("r032_ack7");
    ack0 = 1'b0;
    req_n = 8'hFF;
    ack1  = 1'b1;
    repeat (6) step("drain_b");
    ack1  = 1'b0;

    // overflow: bit 0 falls, rises, falls before ack
    req_n = 8'hFE;
    step("r033_fall1");
    req_n = 8'hFF;
    step("r033_rise");
    req_n = 8'hFE;
    step("r033_fall2");
    check("r033_ovf", {7'd0, ovf0}, 8'd1);
    check("r033_code0", {5'd0, A0, B0, C0}, 8'd0);
    ack0 = 1'b1;
    step("r033_ack");
    ack0 = 1'b0;
    step("r033_once");
    check("r033_single_code", {7'd0, valid0}, 8'd0);
    ovf_clr = 1'b1;
    step("r033_clr");
    ovf_clr = 1'b0;
    check("r033_ovf_cleared", {7'd0, ovf0}, 8'd0);

    // set and clear of the same bit on one edge: set wins, no overflow
    req_n = 8'hFF;
    step("r023_rise");
    req_n = 8'hFE;
    step("r023_capture");
    req_n = 8'hFF;
    step("r023_present");
    req_n = 8'hFE;
    ack0  = 1'b1;
    step("r023_ack_and_set");
    ack0  = 1'b0;
    check("r023_ovf", {7'd0, ovf0}, 8'd0);
    step("r023_repr");
    check("r023_valid", {7'd0, valid0}, 8'd1);
    ack0 = 1'b1;
    step("r023_ack2");
    ack0 = 1'b0;
    req_n = 8'hFF;
    ack1  = 1'b1;
    repeat (6) step("drain_c");
    ack1  = 1'b0;

    // enable gating
    en    = 1'b0;
    req_n = 8'hEF;
    step("r034_capture");
    req_n = 8'hFF;
    step("r034_wait_a");
    step("r034_wait_b");
    check("r034_no_valid", {7'd0, valid0}, 8'd0);
    en = 1'b1;
    step("r034_enable");
    check("r034_valid", {7'd0, valid0}, 8'd1);
    check("r034_code4", {5'd0, A0, B0, C0}, 8'd4);

    // asynchronous reset mid-PRESENT
    #2;
    rst_n = 1'b0;
    #1;
    check("r029_valid0", {7'd0, valid0}, 8'd0);
    check("r029_code0", {5'd0, A0, B0, C0}, 8'd0);
    check("r029_valid1", {7'd0, valid1}, 8'd0);
    model_reset();
    compare_all("r029_async");

    // request held low through reset release
    req_n = 8'hFD;
    @(posedge clk);
    #1;
    compare_all("r028_in_reset");
    rst_n = 1'b1;
    step("r028_capture");
    step("r028_present");
    check("r028_code1", {5'd0, A0, B0, C0}, 8'd1);
    check("r028_valid", {7'd0, valid0}, 8'd1);
    req_n = 8'hFF;
    ack0  = 1'b1;
    ack1  = 1'b1;
    repeat (6) step("drain_d");
    ack0  = 1'b0;

    // level mode: bit 5 held low, acked continuously
    req_n = 8'hDF;
    step("r035_capture");
    for (int k = 0; k < 8; k++) begin
      step("r035_cycle");
      check("r035_valid", {7'd0, valid1}, (k % 2 == 0) ? 8'd1 : 8'd0);
      check("r035_code5", {5'd0, A1, B1, C1}, 8'd5);
      check("r035_ovf", {7'd0, ovf1}, 8'd0);
    end
    ack1  = 1'b0;
    req_n = 8'hFF;

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      req_n   = 8'($urandom) | 8'($urandom);
      en      = ($urandom_range(0, 7) != 0);
      ack0    = 1'($urandom_range(0, 1));
      ack1    = 1'($urandom_range(0, 1));
      ovf_clr = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
